// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode, ALU-op, control-bundle and FSM definitions
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_XOR   = 3'd2,
    OP_ADD   = 3'd3,
    OP_LSL   = 3'd4,
    OP_LSR   = 3'd5,
    OP_BNEZ  = 3'd6,
    OP_RLSL  = 3'd7
  } opcode_e;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_XOR  = 3'd1;
  localparam logic [2:0] ALU_LSL  = 3'd2;
  localparam logic [2:0] ALU_LSR  = 3'd3;
  localparam logic [2:0] ALU_BNEZ = 3'd4;
  localparam logic [2:0] ALU_RLSL = 3'd5;
  localparam logic [2:0] ALU_IDLE = 3'd7;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic branch_en;
    logic alu_src;
  } ctrl_flags_t;

  localparam ctrl_flags_t FLAGS_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR       = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Load write-back is withheld until the memory latency has elapsed.
  function automatic ctrl_flags_t mask_writeback(input ctrl_flags_t f);
    ctrl_flags_t r;
    r            = f;
    r.reg_write  = 1'b0;
    r.mem_to_reg = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode to control-bundle decoder
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OPW    = 3,
  parameter int ALUOPW = 3
) (
  input  logic [OPW-1:0]    opcode,
  output ctrl_flags_t       flags,
  output logic [ALUOPW-1:0] alu_op,
  output logic              illegal
);

  logic [2:0] alu3;

  always_comb begin
    flags   = FLAGS_NONE;
    alu3    = ALU_IDLE;
    illegal = (32'(opcode) > 32'd7);
    if (!illegal) begin
      case (opcode_e'(opcode[2:0]))
        OP_LOAD:  begin flags = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; alu3 = ALU_IDLE; end
        OP_STORE: begin flags = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; alu3 = ALU_IDLE; end
        OP_XOR:   begin flags = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; alu3 = ALU_XOR;  end
        OP_ADD:   begin flags = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; alu3 = ALU_ADD;  end
        OP_LSL:   begin flags = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; alu3 = ALU_LSL;  end
        OP_LSR:   begin flags = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; alu3 = ALU_LSR;  end
        OP_BNEZ:  begin flags = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; alu3 = ALU_BNEZ; end
        OP_RLSL:  begin flags = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; alu3 = ALU_RLSL; end
        default:  ;
      endcase
    end
  end

  assign alu_op = ALUOPW'(alu3);

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - registered instruction sequencer with memory stall,
// branch flush and sticky illegal-opcode flag
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW     = 3,
  parameter int ALUOPW  = 3,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic              branch_taken,
  output logic              ctrl_valid,
  output logic              reg_write,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              branch_en,
  output logic              alu_src,
  output logic [ALUOPW-1:0] alu_op,
  output logic              flush,
  output logic              illegal
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [ALUOPW-1:0] ALU_DEFAULT = ALUOPW'(ALU_IDLE);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  ctrl_flags_t       out_flags_q, out_flags_d;
  logic [ALUOPW-1:0] out_alu_q, out_alu_d;
  ctrl_flags_t       hold_flags_q, hold_flags_d;
  logic [ALUOPW-1:0] hold_alu_q, hold_alu_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              illegal_q, illegal_d;

  ctrl_flags_t       dec_flags;
  logic [ALUOPW-1:0] dec_alu;
  logic              dec_illegal;
  logic              xfer;
  logic              dec_is_mem;

  control_decode #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_decode (
    .opcode  (opcode),
    .flags   (dec_flags),
    .alu_op  (dec_alu),
    .illegal (dec_illegal)
  );

  assign instr_ready = (state_q == ST_RUN);
  assign xfer        = instr_valid & instr_ready;
  assign dec_is_mem  = dec_flags.mem_write | dec_flags.mem_to_reg;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_flags_d  = FLAGS_NONE;
    out_alu_d    = ALU_DEFAULT;
    hold_flags_d = hold_flags_q;
    hold_alu_d   = hold_alu_q;
    valid_d      = 1'b0;
    flush_d      = 1'b0;
    illegal_d    = illegal_q | (xfer & dec_illegal);

    case (state_q)
      ST_RUN: begin
        if (xfer) begin
          hold_flags_d = dec_flags;
          hold_alu_d   = dec_alu;
          out_alu_d    = dec_alu;
          if (dec_is_mem && (MEM_LAT > 0)) begin
            state_d     = ST_MEM_WAIT;
            cnt_d       = CW'(MEM_LAT);
            out_flags_d = mask_writeback(dec_flags);
          end else begin
            out_flags_d = dec_flags;
            valid_d     = 1'b1;
            if (dec_flags.branch_en) begin
              state_d = ST_BR;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        out_alu_d = hold_alu_q;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = ST_RUN;
          out_flags_d = hold_flags_q;
          valid_d     = 1'b1;
        end else begin
          out_flags_d = mask_writeback(hold_flags_q);
        end
      end
      // The branch bundle is on the outputs this cycle; the ALU result decides the flush.
      ST_BR: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      out_flags_q  <= FLAGS_NONE;
      out_alu_q    <= ALU_DEFAULT;
      hold_flags_q <= FLAGS_NONE;
      hold_alu_q   <= ALU_DEFAULT;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_flags_q  <= out_flags_d;
      out_alu_q    <= out_alu_d;
      hold_flags_q <= hold_flags_d;
      hold_alu_q   <= hold_alu_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ctrl_valid = valid_q;
  assign reg_write  = out_flags_q.reg_write;
  assign mem_write  = out_flags_q.mem_write;
  assign mem_to_reg = out_flags_q.mem_to_reg;
  assign branch_en  = out_flags_q.branch_en;
  assign alu_src    = out_flags_q.alu_src;
  assign alu_op     = out_alu_q;
  assign flush      = flush_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

  localparam int OPW     = 4;
  localparam int ALUOPW  = 3;
  localparam int ML      = 2;
  localparam int NEVER   = 32'h7fff_ffff;

  logic              clk;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [OPW-1:0]    opcode;
  logic              branch_taken;
  logic              ctrl_valid;
  logic              reg_write;
  logic              mem_write;
  logic              mem_to_reg;
  logic              branch_en;
  logic              alu_src;
  logic [ALUOPW-1:0] alu_op;
  logic              flush;
  logic              illegal;

  control_sequencer #(
    .OPW     (OPW),
    .ALUOPW  (ALUOPW),
    .MEM_LAT (ML)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ctrl_valid   (ctrl_valid),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .branch_en    (branch_en),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .flush        (flush),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Reference model state: retire schedule, per-cycle expectations, accept window.
  typedef struct {
    int         cyc;
    logic [7:0] b;
  } ret_t;

  ret_t retq[$];
  bit   exp_flush[int];
  bit   exp_memw[int];
  int   next_accept = 0;
  int   ill_from    = NEVER;
  int   br_cyc      = -1;
  bit   br_val      = 1'b0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    else
      passes++;
  endtask

  // {reg_write, mem_write, mem_to_reg, branch_en, alu_src, alu_op}
  function automatic logic [7:0] ref_bundle(input int op);
    case (op)
      0:       return 8'b10100_111;
      1:       return 8'b01000_111;
      2:       return 8'b10001_001;
      3:       return 8'b10000_000;
      4:       return 8'b10000_010;
      5:       return 8'b10000_011;
      6:       return 8'b00010_100;
      7:       return 8'b10001_101;
      default: return 8'b00000_111;
    endcase
  endfunction

  task automatic model_clear();
    retq.delete();
    exp_flush.delete();
    exp_memw.delete();
    ill_from = NEVER;
    br_cyc   = -1;
  endtask

  task automatic model_accept(input int op, input int tk);
    int k;
    bit t;
    k = cyc;
    if (op > 7 && ill_from > k + 1) ill_from = k + 1;
    if (op == 0 || op == 1) begin
      retq.push_back('{k + 1 + ML, ref_bundle(op)});
      next_accept = k + 1 + ML;
      if (op == 1)
        for (int i = 1; i <= ML + 1; i++) exp_memw[k + i] = 1'b1;
    end else if (op == 6) begin
      t = (tk < 0) ? 1'($urandom) : tk[0];
      br_cyc = k + 1;
      br_val = t;
      retq.push_back('{k + 1, ref_bundle(op)});
      if (t) begin
        exp_flush[k + 2] = 1'b1;
        next_accept = k + 3;
      end else begin
        next_accept = k + 2;
      end
    end else begin
      retq.push_back('{k + 1, ref_bundle(op)});
      next_accept = k + 1;
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [OPW-1:0] op, input int tk, output bit acc);
    bit rdy;
    @(posedge clk);
    #1;
    rdy = (cyc >= next_accept);
    chk("instr_ready", 9'(instr_ready), 9'(rdy));
    instr_valid  = v;
    opcode       = op;
    branch_taken = (cyc == br_cyc) ? br_val : 1'($urandom);
    acc = v && rdy;
    if (acc) model_accept(int'(op), tk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, -1, acc);
  endtask

  task automatic issue(input int op, input int tk);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) drive_cycle(1'b1, OPW'(op), tk, acc);
    if (!acc) begin
      checks++;
      $display("FAIL issue_timeout op=%0d actual=not_accepted expected=accepted", op);
    end
  endtask

  // Monitor: compares every cycle's outputs against the scheduled expectations.
  always @(negedge clk) begin
    logic [8:0] exp_v;
    logic [8:0] act_v;
    act_v = {ctrl_valid, reg_write, mem_write, mem_to_reg, branch_en, alu_src, alu_op};
    exp_v = {1'b0, 1'b0, 1'(exp_memw.exists(cyc)), 3'b000, 3'b111};
    if (retq.size() > 0 && retq[0].cyc == cyc) begin
      exp_v = {1'b1, retq[0].b};
      void'(retq.pop_front());
    end
    chk("bundle", act_v, exp_v);
    chk("flush", 9'(flush), 9'(exp_flush.exists(cyc)));
    chk("illegal", 9'(illegal), 9'(cyc >= ill_from));
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit acc;
    logic [OPW-1:0] rop;
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    opcode       = '0;
    branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_accept = cyc;
    chk("ready_after_reset", 9'(instr_ready), 9'd1);

    issue(3, -1);
    issue(2, -1);
    issue(0, -1);
    issue(1, -1);
    issue(6, 1);
    issue(6, 0);
    issue(5, -1);
    issue(9, -1);
    issue(3, -1);
    issue(7, -1);
    issue(4, -1);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      rop = (($urandom % 32) == 0) ? OPW'(8 + ($urandom % 8)) : OPW'($urandom % 8);
      drive_cycle(($urandom % 4) != 0, rop, -1, acc);
    end
    idle(6);

    // Abort a store mid-stall with an asynchronous reset.
    issue(1, -1);
    idle(1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("reset_bundle", {ctrl_valid, reg_write, mem_write, mem_to_reg, branch_en, alu_src, alu_op},
        9'b0_00000_111);
    chk("reset_flush", 9'(flush), 9'd0);
    chk("reset_illegal", 9'(illegal), 9'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_accept = cyc;
    chk("ready_after_abort", 9'(instr_ready), 9'd1);
    idle(6);
    issue(3, -1);
    issue(2, -1);
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
